usb_host_line_tx: RTL and testbench

//  Synthesizable parametrised successor to the bench's hand-driven host line driver. Serialises a

---
 rtl/usb_host_line_tx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_usb_host_line_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_host_line_tx.sv
// usb_host_line_tx: serialises a byte stream onto a USB D+/D- pair as
// SYNC, NRZI-encoded bit-stuffed data, then EOP (SE0 followed by J).
// Optional feature macro: USB_HOST_TX_LOW_SPEED_EN adds a low_speed input
// selecting 1.5 Mbps timing and low-speed J/K polarity for each packet.
module usb_host_line_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1
) (
    input  logic       clk_48mhz,
    input  logic       reset,
`ifdef USB_HOST_TX_LOW_SPEED_EN
    input  logic       low_speed,
`endif
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_underrun,
    output logic       usb_host_p_tx,
    output logic       usb_host_n_tx,
    output logic       usb_host_tx_en
);

    localparam int TW = $clog2(CLKS_PER_BIT * 8);
    localparam logic [TW-1:0] FS_MAX   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] LS_MAX   = TW'(CLKS_PER_BIT * 8 - 1);
    localparam logic [2:0]    SE0_LAST = 3'(EOP_SE0_BITS - 1);
    localparam logic [2:0]    J_LAST   = 3'(EOP_J_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;     // bit index within SYNC/byte/EOP phase
    logic [2:0]    ones_q, ones_d;   // consecutive ones on the wire
    logic          stuff_q, stuff_d; // current bit is an inserted stuff bit
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          lvl_q, lvl_d;     // NRZI line level: 1 = J, 0 = K
    logic          ls_q, ls_d;       // low-speed timing/polarity for this packet
    logic          p_q, p_d;
    logic          n_q, n_d;
    logic          en_q, en_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;

    logic          ls_in;
    logic [TW-1:0] tmax;
    logic [TW-1:0] tpre;
    logic          strobe;
    logic          eob;
    logic          accept;
    logic          bit_go;
    logic          bit_val;
    logic [2:0]    ones_base;
    logic          se0_d;

`ifdef USB_HOST_TX_LOW_SPEED_EN
    assign ls_in = low_speed;
`else
    assign ls_in = 1'b0;
`endif

    assign tmax   = ls_q ? LS_MAX : FS_MAX;
    assign tpre   = tmax - TW'(1);
    assign strobe = (timer_q == tmax);
    assign accept = ready_q && tx_valid;
    // Final wire bit of the current byte: bit 7, unless a stuff bit still follows it.
    assign eob    = (state_q == S_DATA) && (idx_q == 3'd7) && (stuff_q || (ones_q != 3'd6));

    assign tx_ready       = ready_q;
    assign tx_busy        = busy_q;
    assign tx_underrun    = underrun_q;
    assign usb_host_p_tx  = p_q;
    assign usb_host_n_tx  = n_q;
    assign usb_host_tx_en = en_q;

    // Next-state: bit timing, sequencing, NRZI/stuffing and registered output values.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        stuff_d    = stuff_q;
        data_d     = data_q;
        last_d     = last_q;
        lvl_d      = lvl_q;
        ls_d       = ls_q;
        ready_d    = 1'b0;
        underrun_d = 1'b0;
        bit_go     = 1'b0;
        bit_val    = 1'b0;
        ones_base  = ones_q;
        se0_d      = 1'b0;
        p_d        = 1'b1;
        n_d        = 1'b0;
        en_d       = 1'b0;
        busy_d     = 1'b0;

        if (state_q != S_IDLE) begin
            timer_d = strobe ? '0 : timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                timer_d = '0;
                if (accept) begin
                    state_d = S_SYNC;
                    ls_d    = ls_in;
                    data_d  = tx_data;
                    last_d  = tx_last;
                    idx_d   = 3'd0;
                    stuff_d = 1'b0;
                    lvl_d   = 1'b0;   // first SYNC bit is a 0: J -> K
                    ready_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (strobe) begin
                    if (idx_q == 3'd7) begin
                        state_d   = S_DATA;
                        idx_d     = 3'd0;
                        stuff_d   = 1'b0;
                        ones_base = 3'd1;   // SYNC's final 1 counts toward stuffing
                        bit_go    = 1'b1;
                        bit_val   = data_q[0];
                    end else begin
                        idx_d = idx_q + 3'd1;
                        // SYNC is seven 0s then a 1: only the last bit holds the level
                        if (idx_q != 3'd6) begin
                            lvl_d = ~lvl_q;
                        end
                    end
                end
            end
            S_DATA: begin
                // Request the next byte during the strobe cycle that ends this byte
                if (eob && !last_q && (timer_q == tpre)) begin
                    ready_d = 1'b1;
                end
                if (strobe) begin
                    if (eob) begin
                        if (!last_q && tx_valid) begin
                            data_d  = tx_data;
                            last_d  = tx_last;
                            idx_d   = 3'd0;
                            stuff_d = 1'b0;
                            bit_go  = 1'b1;
                            bit_val = tx_data[0];
                        end else begin
                            underrun_d = ~last_q;
                            state_d    = S_EOP_SE0;
                            idx_d      = 3'd0;
                            stuff_d    = 1'b0;
                            ones_d     = 3'd0;
                        end
                    end else if (!stuff_q && (ones_q == 3'd6)) begin
                        stuff_d = 1'b1;
                        ones_d  = 3'd0;
                        lvl_d   = ~lvl_q;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        stuff_d = 1'b0;
                        bit_go  = 1'b1;
                        bit_val = data_q[idx_q + 3'd1];
                    end
                end
            end
            S_EOP_SE0: begin
                if (strobe) begin
                    if (idx_q == SE0_LAST) begin
                        state_d = S_EOP_J;
                        idx_d   = 3'd0;
                        lvl_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (strobe) begin
                    if (idx_q == J_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                        lvl_d   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                lvl_d   = 1'b1;
            end
        endcase

        // NRZI: a 0 toggles the line and breaks the run of ones; a 1 holds it
        if (bit_go) begin
            if (bit_val) begin
                ones_d = ones_base + 3'd1;
            end else begin
                ones_d = 3'd0;
                lvl_d  = ~lvl_q;
            end
        end

        // Low-speed swaps which wire carries J
        se0_d  = (state_d == S_EOP_SE0);
        p_d    = !se0_d && (lvl_d ^ ls_d);
        n_d    = !se0_d && !(lvl_d ^ ls_d);
        en_d   = (state_d != S_IDLE);
        busy_d = en_d;
    end

    // State and output registers; reset drops the bus straight to full-speed J idle.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            idx_q      <= 3'd0;
            ones_q     <= 3'd0;
            stuff_q    <= 1'b0;
            data_q     <= 8'd0;
            last_q     <= 1'b0;
            lvl_q      <= 1'b1;
            ls_q       <= 1'b0;
            p_q        <= 1'b1;
            n_q        <= 1'b0;
            en_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            ones_q     <= ones_d;
            stuff_q    <= stuff_d;
            data_q     <= data_d;
            last_q     <= last_d;
            lvl_q      <= lvl_d;
            ls_q       <= ls_d;
            p_q        <= p_d;
            n_q        <= n_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_usb_host_line_tx.sv
// Bench for usb_host_line_tx: a symbol-level packet model (SYNC, NRZI,
// stuffing, EOP) expanded to per-cycle expectations, checked every cycle.
module tb_usb_host_line_tx;
    localparam int CPB  = 4;
    localparam int SE0B = 2;
    localparam int JB   = 1;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] tx_data   = 8'd0;
    logic       tx_valid  = 1'b0;
    logic       tx_last   = 1'b0;
`ifdef USB_HOST_TX_LOW_SPEED_EN
    logic       low_speed = 1'b0;
`endif
    logic tx_ready, tx_busy, tx_underrun, usb_host_p_tx, usb_host_n_tx, usb_host_tx_en;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_host_line_tx #(.CLKS_PER_BIT(CPB), .EOP_SE0_BITS(SE0B), .EOP_J_BITS(JB)) dut (
        .clk_48mhz      (clk_48mhz),
        .reset          (reset),
`ifdef USB_HOST_TX_LOW_SPEED_EN
        .low_speed      (low_speed),
`endif
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_last        (tx_last),
        .tx_ready       (tx_ready),
        .tx_busy        (tx_busy),
        .tx_underrun    (tx_underrun),
        .usb_host_p_tx  (usb_host_p_tx),
        .usb_host_n_tx  (usb_host_n_tx),
        .usb_host_tx_en (usb_host_tx_en)
    );

    typedef struct packed {
        logic en;
        logic p;
        logic n;
        logic rdy;
        logic ur;
    } exp_t;

    exp_t       exp_q[$];
    int         sym_q[$];   // 0 = SE0, 1 = J, 2 = K
    bit         mark_q[$];  // symbol ends a byte that requests a successor
    logic [7:0] pk [4];
    int         total = 0;
    int         passed = 0;
    bit         cmp_on = 0;
    bit         ls_mode = 0;
    bit         prev_en = 0;
    int         en_cnt = 0;
    int         pkt_cyc = 0;
    int         rdy_at = -1;
    int         ur_cnt = 0;
    int         d2_syms [19] = '{2,1,2,1,2,1,2,2, 1,1,2,1,1,2,2,2, 0,0, 1};

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
    endtask

    // Model: wire symbols of a packet, then per-cycle expected outputs.
    task automatic build(input int nb, input bit trunc, input bit ls);
        int   lvl;
        int   ones;
        int   se0_at;
        int   cb;
        exp_t e;
        sym_q.delete();
        mark_q.delete();
        lvl = 1;
        for (int i = 0; i < 8; i++) begin
            if (i != 7) lvl = 3 - lvl;
            sym_q.push_back(lvl); mark_q.push_back(1'b0);
        end
        ones = 1;
        for (int j = 0; j < nb; j++) begin
            for (int i = 0; i < 8; i++) begin
                if (pk[j][i]) ones++;
                else begin ones = 0; lvl = 3 - lvl; end
                sym_q.push_back(lvl); mark_q.push_back(1'b0);
                if (ones == 6) begin
                    lvl = 3 - lvl; ones = 0;
                    sym_q.push_back(lvl); mark_q.push_back(1'b0);
                end
            end
            if (!(j == nb - 1 && !trunc)) mark_q[mark_q.size() - 1] = 1'b1;
        end
        se0_at = sym_q.size();
        for (int i = 0; i < SE0B; i++) begin sym_q.push_back(0); mark_q.push_back(1'b0); end
        for (int i = 0; i < JB; i++) begin sym_q.push_back(1); mark_q.push_back(1'b0); end
        cb = ls ? 8 * CPB : CPB;
        for (int k = 0; k < sym_q.size(); k++) begin
            for (int c = 0; c < cb; c++) begin
                e.en  = 1'b1;
                e.p   = (sym_q[k] == 1) ? !ls : (sym_q[k] == 2) ? ls : 1'b0;
                e.n   = (sym_q[k] == 1) ? ls : (sym_q[k] == 2) ? !ls : 1'b0;
                e.rdy = mark_q[k] && (c == cb - 1);
                e.ur  = trunc && (k == se0_at) && (c == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock: sample at the falling edge and compare against the model.
    task automatic tick();
        exp_t e;
        @(negedge clk_48mhz);
        if (usb_host_tx_en && !prev_en) begin
            en_cnt = 0; pkt_cyc = 0; rdy_at = -1; ur_cnt = 0;
        end
        if (cmp_on) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_en", int'(usb_host_tx_en), int'(e.en));
                check("line_p", int'(usb_host_p_tx), int'(e.p));
                check("line_n", int'(usb_host_n_tx), int'(e.n));
                check("tx_busy", int'(tx_busy), int'(e.en));
                check("tx_ready", int'(tx_ready), int'(e.rdy));
                check("tx_underrun", int'(tx_underrun), int'(e.ur));
            end else begin
                check("idle_en", int'(usb_host_tx_en), 0);
                check("idle_busy", int'(tx_busy), 0);
                check("idle_ready", int'(tx_ready), 1);
                check("idle_underrun", int'(tx_underrun), 0);
                check("idle_p", int'(usb_host_p_tx), int'(!ls_mode));
                check("idle_n", int'(usb_host_n_tx), int'(ls_mode));
            end
        end
        if (usb_host_tx_en) begin
            en_cnt++;
            if (tx_ready) rdy_at = pkt_cyc;
            pkt_cyc++;
        end
        if (tx_underrun) ur_cnt++;
        prev_en = usb_host_tx_en;
    endtask

    task automatic send(input int nb, input bit trunc, input bit ls,
                        input int lit_en, input int lit_rdy, input int lit_ur);
        bit got;
        got = 0;
        for (int g = 0; g < 200 && !got; g++) begin tick(); got = tx_ready; end
        if (!got) check("wait_idle_ready", 0, 1);
        tx_data  = pk[0];
        tx_last  = (nb == 1) && !trunc;
        tx_valid = 1'b1;
`ifdef USB_HOST_TX_LOW_SPEED_EN
        low_speed = ls;
`endif
        ls_mode = ls;
        build(nb, trunc, ls);
        tick();
        for (int j = 1; j < nb; j++) begin
            tx_data = pk[j];
            tx_last = (j == nb - 1);
            got = 0;
            for (int g = 0; g < 2000 && !got; g++) begin tick(); got = tx_ready; end
            if (!got) check("wait_byte_ready", 0, 1);
            tick();
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        for (int g = 0; g < 3000 && exp_q.size() > 0; g++) tick();
        if (exp_q.size() > 0) check("packet_timeout", exp_q.size(), 0);
        exp_q.delete();
        tick();
        check("en_cycles", en_cnt, lit_en);
        check("ready_index", rdy_at, lit_rdy);
        check("underrun_pulses", ur_cnt, lit_ur);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int se0_seen;
        bit got;
        // Reset held three cycles
        reset = 1'b1;
        repeat (3) tick();
        check("rst_p", int'(usb_host_p_tx), 1);
        check("rst_n", int'(usb_host_n_tx), 0);
        check("rst_en", int'(usb_host_tx_en), 0);
        check("rst_ready", int'(tx_ready), 0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", int'(tx_ready), 1);
        cmp_on = 1;

        // Single byte 0xD2 with last
        pk[0] = 8'hD2;
        send(1, 0, 0, 76, -1, 0);
        check("d2_sym_count", sym_q.size(), 19);
        for (int k = 0; k < 19; k++) check("d2_symbol", sym_q[k], d2_syms[k]);

        // 0xFF stuffs mid-byte, then 0x00 back to back
        pk[0] = 8'hFF; pk[1] = 8'h00;
        send(2, 0, 0, 112, 67, 0);
        check("ff_sym_count", sym_q.size(), 28);

        // 0xFC ends on six ones: stuff bit before 0x01 and before the request
        pk[0] = 8'hFC; pk[1] = 8'h01;
        send(2, 0, 0, 112, 67, 0);

        // Underrun after 0x55, then a normal packet
        pk[0] = 8'h55;
        send(1, 1, 0, 76, 63, 1);
        pk[0] = 8'h00;
        send(1, 0, 0, 76, -1, 0);

        // Reset in the middle of DATA
        cmp_on = 0;
        got = 0;
        for (int g = 0; g < 200 && !got; g++) begin tick(); got = tx_ready; end
        if (!got) check("wait_idle_ready", 0, 1);
        tx_data = 8'hA5; tx_last = 1'b1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_last = 1'b0;
        repeat (40) tick();
        check("mid_pkt_en", int'(usb_host_tx_en), 1);
        reset = 1'b1;
        tick();
        check("abort_en", int'(usb_host_tx_en), 0);
        check("abort_p", int'(usb_host_p_tx), 1);
        check("abort_n", int'(usb_host_n_tx), 0);
        check("abort_busy", int'(tx_busy), 0);
        se0_seen = 0;
        repeat (2) begin
            tick();
            if (!usb_host_p_tx && !usb_host_n_tx) se0_seen++;
        end
        check("abort_no_se0", se0_seen, 0);
        reset = 1'b0;
        tick();
        check("abort_ready", int'(tx_ready), 1);
        ls_mode = 0;
        cmp_on = 1;
        pk[0] = 8'h3C;
        send(1, 0, 0, 76, -1, 0);

`ifdef USB_HOST_TX_LOW_SPEED_EN
        pk[0] = 8'hD2;
        send(1, 0, 1, 608, -1, 0);
        pk[0] = 8'hD2;
        send(1, 0, 0, 76, -1, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
